// File: rtl/bc_pkg.sv
// bc_pkg: shared constants for the memory port sequencer.
//   state_t   : sequencer state encoding (IDLE, ACCESS, DONE)
//   OP_RD/OP_WR : recorded operation code
//   BC_ADDR_W / BC_DATA_W : default address and data widths
package bc_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    localparam int BC_ADDR_W = 8;
    localparam int BC_DATA_W = 16;
endpackage

// File: rtl/mem_port.sv
// mem_port: sequences one RAM access per control-unit request between the MAR/MBR datapath and a single-port synchronous RAM.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_rd, req_wr      : one-cycle request pulses (read wins when both are high, and err pulses)
//   addr, wdata         : MAR address and MBR store data, sampled on acceptance
//   rdata               : registered read data, held until the next read completes
//   done, busy, err     : completion pulse, in-flight flag, rejected-request pulse
//   ram_en, ram_we      : one-cycle RAM enable / write enable
//   ram_addr, ram_wdata : latched RAM address and write data
//   ram_rdata           : RAM read data, valid WAIT_STATES+1 edges after the enable edge
module mem_port
    import bc_pkg::*;
#(
    parameter int ADDR_W      = BC_ADDR_W,
    parameter int DATA_W      = BC_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       op;
    logic       req;
    logic       take;

    assign req = req_rd | req_wr;

    // The DONE cycle also accepts a new request so that a control unit
    // reacting to done gets back-to-back accesses every WAIT_STATES+2 cycles.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE, DONE: begin
                take     = req;
                state_nx = req ? ACCESS : IDLE;
            end
            ACCESS:  state_nx = (cnt == 4'd0) ? DONE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cnt       <= 4'd0;
            op        <= OP_RD;
        end else begin
            ram_en <= take;
            ram_we <= take && !req_rd;
            done   <= state_nx == DONE;
            busy   <= state_nx != IDLE;
            // Rejected: anything arriving mid-access, or a read+write collision.
            err    <= req && (state == ACCESS || (req_rd && req_wr));
            if (take) begin
                ram_addr <= addr;
                op       <= req_rd ? OP_RD : OP_WR;
                cnt      <= 4'(WAIT_STATES);
                if (!req_rd)
                    ram_wdata <= wdata;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS && cnt == 4'd0 && op == OP_RD)
                rdata <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: drives three mem_port builds (WAIT_STATES 0, 1, 3) with shared stimulus and checks them against a transaction-timing model.
module tb_mem_port;
    typedef logic [44:0] obs_t;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic        e_done;
        logic        e_busy;
        logic        e_en;
        logic        e_we;
        logic        e_err;
        logic [15:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [15:0] wdata = 16'h0000;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [15:0] pre_val = 16'h0000;
    obs_t        act [3];
    obs_t        expv [3];
    int          vectors = 0;
    int          fails = 0;
    int          ec [3];
    int          nc [3];
    int          wc [3];
    int          dc [3];
    vec_t        tbl [11];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        logic [15:0] rdata, ram_wdata, ram_rdata;
        logic        done, busy, err, ram_en, ram_we;
        logic [7:0]  ram_addr;
        logic [15:0] mem [256];
        logic [15:0] refmem [256];
        int          k = 0;
        int          n = 0;
        int          acc = -1;
        logic        op_rd = 1'b0;
        logic [7:0]  m_addr = 8'h00;
        logic [15:0] m_wdata = 16'h0000;
        logic [15:0] m_rdata = 16'h0000;
        logic        e_err = 1'b0;
        logic        occ, take;

        mem_port #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(W)) dut (
            .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
            .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
            .busy(busy), .err(err), .ram_en(ram_en), .ram_we(ram_we),
            .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
        );

        // RAM: data only becomes visible W+1 edges after the enable edge.
        always @(posedge clk) begin
            if (pre_en)
                mem[pre_addr] <= pre_val;
            else if (ram_en && ram_we)
                mem[ram_addr] <= ram_wdata;
            k <= ram_en ? 1 : (k != 0 && k < 64) ? k + 1 : k;
        end
        assign ram_rdata = ((W == 0 && ram_en) || (k != 0 && k >= W)) ? mem[ram_addr] : 16'hDEAD;

        // Model: an accepted request at edge acc occupies edges acc+1..acc+W+1.
        assign occ  = acc >= 0 && n > acc && n <= acc + W + 1;
        assign take = !occ && (req_rd || req_wr);
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc     <= -1;
                m_addr  <= 8'h00;
                m_wdata <= 16'h0000;
                m_rdata <= 16'h0000;
                e_err   <= 1'b0;
            end else begin
                n     <= n + 1;
                e_err <= (req_rd || req_wr) && (occ || (req_rd && req_wr));
                if (pre_en)
                    refmem[pre_addr] <= pre_val;
                if (take) begin
                    acc    <= n;
                    op_rd  <= req_rd;
                    m_addr <= addr;
                    if (!req_rd) begin
                        m_wdata      <= wdata;
                        refmem[addr] <= wdata;
                    end
                end
                if (acc >= 0 && n == acc + W + 1 && op_rd)
                    m_rdata <= refmem[m_addr];
            end
        end

        assign act[g]  = {rdata, done, busy, err, ram_en, ram_we, ram_addr, ram_wdata};
        assign expv[g] = {m_rdata,
                          acc >= 0 && n - 1 == acc + W + 1,
                          acc >= 0 && n - 1 <= acc + W + 1,
                          e_err,
                          acc >= 0 && acc == n - 1,
                          acc >= 0 && acc == n - 1 && !op_rd,
                          m_addr, m_wdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (act[i] !== expv[i]) begin
                fails++;
                $display("FAIL model inst%0d: got %h want %h", i, act[i], expv[i]);
            end
            if (act[i][26]) ec[i]++;
            if (act[i][25]) nc[i]++;
            if (act[i][24]) wc[i]++;
            if (act[i][28]) dc[i]++;
        end
    endtask

    task automatic check(input string name, input int i, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s inst%0d: got %h want %h", name, i, got, want);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            ec[i] = 0;
            nc[i] = 0;
            wc[i] = 0;
            dc[i] = 0;
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        req_rd = rd;
        req_wr = wr;
        addr   = a;
        wdata  = d;
        tick();
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic lat_test(input logic [7:0] a, input logic [15:0] v);
        int lat [3];
        int ws [3];
        ws = '{1, 2, 4};
        lat = '{-1, -1, -1};
        drive(1'b1, 1'b0, a, 16'h0000);
        for (int j = 1; j <= 10; j++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (lat[i] < 0 && act[i][28]) lat[i] = j;
        end
        for (int i = 0; i < 3; i++) begin
            check("done_latency", i, 64'(lat[i]), 64'(ws[i]));
            check("read_data", i, 64'(act[i][44:29]), 64'(v));
        end
    endtask

    task automatic counts(input string name, input int e_err, input int e_en, input int e_we, input logic [15:0] e_rd);
        for (int i = 0; i < 3; i++) begin
            check({name, "_err"}, i, 64'(ec[i]), 64'(e_err));
            check({name, "_en"}, i, 64'(nc[i]), 64'(e_en));
            check({name, "_we"}, i, 64'(wc[i]), 64'(e_we));
            check({name, "_rdata"}, i, 64'(act[i][44:29]), 64'(e_rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            check("reset_state", i, 64'(act[i]), 64'h0);
        rst_n = 1'b1;

        preload(8'h05, 16'h0000);
        preload(8'h12, 16'hBEEF);
        preload(8'h20, 16'h0F0F);
        preload(8'h30, 16'hA5A5);
        for (int i = 0; i < 16; i++)
            preload(8'hF0 | 8'(i), 16'($urandom));

        // W=1 build: read 0x12, write 0x1234 to 0x05, read 0x05 back at E3.
        tbl[0]  = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[4]  = '{1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[7]  = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
        for (int r = 0; r < 11; r++) begin
            req_rd = tbl[r].rd;
            req_wr = tbl[r].wr;
            addr   = tbl[r].a;
            wdata  = tbl[r].d;
            tick();
            check("table_row", r, 64'({act[1][28], act[1][27], act[1][25], act[1][24], act[1][26], act[1][44:29]}),
                  64'({tbl[r].e_done, tbl[r].e_busy, tbl[r].e_en, tbl[r].e_we, tbl[r].e_err, tbl[r].e_rdata}));
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
        repeat (6) tick();

        lat_test(8'h30, 16'hA5A5);

        clr();
        drive(1'b1, 1'b0, 8'h12, 16'h0000);
        drive(1'b0, 1'b1, 8'h40, 16'h1111);
        repeat (6) tick();
        counts("busy_req", 1, 1, 0, 16'hBEEF);

        clr();
        drive(1'b1, 1'b1, 8'h20, 16'hFFFF);
        repeat (6) tick();
        counts("rd_wr_collide", 1, 1, 0, 16'h0F0F);

        drive(1'b1, 1'b0, 8'h12, 16'h0000);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check("async_reset", i, 64'(act[i]), 64'h0);
        tick();
        rst_n = 1'b1;
        clr();
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            check("no_done_after_abort", i, 64'(dc[i]), 64'h0);
        lat_test(8'h12, 16'hBEEF);

        for (int c = 0; c < 400; c++) begin
            int p;
            p = int'($urandom_range(0, 99));
            req_rd = p < 15 || (p >= 30 && p < 34);
            req_wr = (p >= 15 && p < 34);
            addr   = 8'hF0 | 8'($urandom_range(0, 15));
            wdata  = 16'($urandom);
            tick();
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
